// File: rtl/tiny_memory_burst_master.sv
// Burst initiator for a tiny memory: turns one (addr, len, dir) command into
// single-cycle sel strobes, streaming beats through valid/ready handshakes.
module tiny_memory_burst_master #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 198,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_done,
  output logic              busy,
  output logic              burst_done,
  output logic              err_timeout
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    PUSH   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t             state;
  logic               write_q;
  logic [LEN_W-1:0]   remaining;
  logic [TCNT_W-1:0]  tcnt;

  // Handshake and strobe outputs decode the state register only, so no
  // input can reach an output combinationally.
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wr_ready   = (state == FETCH);
  assign rd_valid   = (state == PUSH);
  assign mem_sel    = (state == ISSUE);
  assign mem_w      = (state == ISSUE) && write_q;
  assign burst_done = (state == FINISH);

  // Burst sequencer; mem_addr doubles as the running beat address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      mem_addr    <= '0;
      remaining   <= '0;
      tcnt        <= '0;
      mem_data    <= '0;
      rd_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q     <= cmd_write;
            mem_addr    <= cmd_addr;
            remaining   <= cmd_len;
            tcnt        <= '0;
            err_timeout <= 1'b0;
            if (cmd_len == '0) begin
              state <= FINISH;
            end else if (cmd_write) begin
              state <= FETCH;
            end else begin
              state <= ISSUE;
            end
          end
        end
        FETCH: begin
          if (wr_valid) begin
            mem_data <= wr_data;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (mem_done) begin
            tcnt      <= '0;
            mem_addr  <= mem_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (!write_q) begin
              rd_data <= mem_out;
              state   <= PUSH;
            end else if (remaining == LEN_W'(1)) begin
              state <= FINISH;
            end else begin
              state <= FETCH;
            end
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            tcnt        <= '0;
            err_timeout <= 1'b1;
            state       <= FINISH;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        PUSH: begin
          if (rd_ready) begin
            state <= (remaining == '0) ? FINISH : ISSUE;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_memory_burst_master.sv
// Directed bench for tiny_memory_burst_master with a behavioural tiny memory
// whose done flag can be suppressed to provoke the access timeout.
module tb_tiny_memory_burst_master;

  localparam int AW = 6;
  localparam int DW = 198;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic          mem_w;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;
  logic          mem_done;
  logic          busy;
  logic          burst_done;
  logic          err_timeout;

  tiny_memory_burst_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_w(mem_w), .mem_data(mem_data),
    .mem_out(mem_out), .mem_done(mem_done),
    .busy(busy), .burst_done(burst_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural memory: done and read data registered one cycle after sel.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          no_done = 1'b0;
  always @(posedge clk) begin
    mem_done <= mem_sel && !no_done;
    if (mem_sel && mem_w) mem[mem_addr] <= mem_data;
    if (mem_sel && !mem_w) mem_out <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            sel_addr[$];
  int            sel_w[$];
  int            sel_cyc[$];
  logic [DW-1:0] rdv[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            stab_err = 0;
  int            sel_in_stall = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (mem_sel) begin
      sel_addr.push_back(int'(mem_addr));
      sel_w.push_back(int'(mem_w));
      sel_cyc.push_back(cyc);
    end
    if (burst_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rd_valid && rd_ready) rdv.push_back(rd_data);
    if (prev_stall && rd_valid && rd_data !== prev_data) stab_err <= stab_err + 1;
    if (prev_stall && mem_sel) sel_in_stall <= sel_in_stall + 1;
    prev_stall <= rd_valid && !rd_ready;
    prev_data  <= rd_data;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int s);
    logic [31:0] w;
    w = (s * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    return {s[5:0], {6{w}}};
  endfunction

  task automatic send_cmd(input logic w, input int a, input int l, output int acc);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a[AW-1:0]; cmd_len = l[AW:0];
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (acc < 0) check("cmd_accept", 1, 0);
  endtask

  task automatic wait_done(input int base);
    int seen;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (done_cnt > base) begin seen = 1; break; end
    end
    check("burst_done_seen", seen, 1);
    #1;
  endtask

  task automatic write_burst(input int a, input int l, input int seed);
    int acc, base, ok;
    base = done_cnt;
    send_cmd(1'b1, a, l, acc);
    for (int i = 0; i < l; i++) begin
      wr_data = pat(seed + i); wr_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (wr_ready) begin ok = 1; break; end
      end
      if (ok == 0) check("wr_ready_seen", 0, 1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wait_done(base);
  endtask

  task automatic read_burst(input int a, input int l, input logic toggle);
    int acc, base;
    base = done_cnt;
    rd_ready = toggle ? 1'b0 : 1'b1;
    send_cmd(1'b0, a, l, acc);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (toggle) rd_ready = ~rd_ready;
      if (done_cnt > base) break;
    end
    rd_ready = 1'b1;
    check("read_done_seen", done_cnt > base, 1);
  endtask

  initial begin
    int sb, rb, acc, dc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_sel", mem_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1);

    // Write burst addr 5, len 3
    sb = sel_addr.size();
    write_burst(5, 3, 1);
    check("wr_sel_count", sel_addr.size() - sb, 3);
    for (int i = 0; i < 3; i++) begin
      check("wr_sel_addr", sel_addr[sb+i], 5 + i);
      check("wr_sel_w", sel_w[sb+i], 1);
      check("wr_mem", mem[5+i], pat(1 + i));
    end
    check("wr_spacing1", sel_cyc[sb+1] - sel_cyc[sb], 3);
    check("wr_spacing2", sel_cyc[sb+2] - sel_cyc[sb+1], 3);
    check("wr_done_time", done_cyc, sel_cyc[sb+2] + 2);
    check("wr_mem_data_hold", mem_data, pat(3));

    // Read burst addr 5, len 3, rd_ready high
    sb = sel_addr.size(); rb = rdv.size();
    read_burst(5, 3, 1'b0);
    check("rd_sel_count", sel_addr.size() - sb, 3);
    check("rd_beats", rdv.size() - rb, 3);
    for (int i = 0; i < 3; i++) begin
      check("rd_sel_w", sel_w[sb+i], 0);
      check("rd_data_seq", rdv[rb+i], pat(1 + i));
    end
    check("rd_done_time", done_cyc, sel_cyc[sb+2] + 3);
    check("rd_data_hold", rd_data, pat(3));

    // Wrap: write then read 62..1 with a stalling consumer
    write_burst(62, 4, 10);
    sb = sel_addr.size(); rb = rdv.size();
    read_burst(62, 4, 1'b1);
    check("wrap_sel_count", sel_addr.size() - sb, 4);
    check("wrap_a0", sel_addr[sb], 62);
    check("wrap_a1", sel_addr[sb+1], 63);
    check("wrap_a2", sel_addr[sb+2], 0);
    check("wrap_a3", sel_addr[sb+3], 1);
    check("wrap_beats", rdv.size() - rb, 4);
    for (int i = 0; i < 4; i++) check("wrap_data", rdv[rb+i], pat(10 + i));
    check("wrap_stable", stab_err, 0);
    check("wrap_no_sel_stalled", sel_in_stall, 0);

    // Timeout: memory never answers
    no_done = 1'b1;
    sb = sel_addr.size(); rb = rdv.size();
    read_burst(9, 2, 1'b0);
    no_done = 1'b0;
    check("to_sel_count", sel_addr.size() - sb, 1);
    check("to_done_time", done_cyc, sel_cyc[sb] + 1 + TO);
    check("to_err", err_timeout, 1);
    check("to_no_beats", rdv.size() - rb, 0);

    // len 0 clears the sticky error and issues no access
    sb = sel_addr.size(); dc = done_cnt;
    send_cmd(1'b0, 3, 0, acc);
    check("len0_err_clear", err_timeout, 0);
    wait_done(dc);
    check("len0_done_time", done_cyc, acc);
    check("len0_no_sel", sel_addr.size() - sb, 0);
    check("len0_cmd_ready", cmd_ready, 1);

    // Reset during WAIT of beat 2 of a write burst
    sb = sel_addr.size(); dc = done_cnt;
    send_cmd(1'b1, 20, 3, acc);
    wr_data = pat(20); wr_valid = 1'b1;
    begin
      int hit;
      hit = 0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (sel_addr.size() >= sb + 2) begin hit = 1; break; end
      end
      check("rstmid_reached", hit, 1);
    end
    reset = 1'b1;
    #1;
    check("rstmid_sel", mem_sel, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_wr_ready", wr_ready, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    check("rstmid_mem_data", mem_data, 0);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_done", done_cnt, dc);
    check("rstmid_sel_count", sel_addr.size() - sb, 2);
    sb = sel_addr.size();
    write_burst(40, 1, 30);
    check("post_rst_sel_count", sel_addr.size() - sb, 1);
    check("post_rst_addr", sel_addr[sb], 40);
    check("post_rst_mem", mem[40], pat(30));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
